dense_layer_seq: RTL
====================

DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

Interface
REQ-001 SHALL have parameter IN_SIZE, default IN_SIZE_2 (nn_parameters), meaning input vector length (2..256).
REQ-002 SHALL have parameter OUT_SIZE, default OUT_SIZE_2 (nn_parameters), meaning neuron count (1..256).
REQ-003 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to evaluate the layer.
REQ-006 SHALL have port abort  in  1  synchronous cancel of a running evaluation.
REQ-007 SHALL have port in_addr  out  clog2(IN_SIZE)  input-vector read address.
REQ-008 SHALL have port in_data  in  8 signed  input element, valid one cycle after in_addr.
REQ-009 SHALL have port w_addr  out  clog2(OUT_SIZE*IN_SIZE)  weight read address, row-major: i*IN_SIZE+j.
REQ-010 SHALL have port w_data  in  8 signed  weight, valid one cycle after w_addr.
REQ-011 SHALL have port b_addr  out  clog2(OUT_SIZE)  bias read address.
REQ-012 SHALL have port b_data  in  8 signed  bias, valid one cycle after b_addr.
REQ-013 SHALL have port out_valid  out  1  one-cycle strobe qualifying out_idx/out_data.
REQ-014 SHALL have port out_idx  out  clog2(OUT_SIZE)  neuron index of out_data.
REQ-015 SHALL have port out_data  out  8 signed  activated neuron result.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse after the last neuron is emitted.

Function
REQ-018 SHALL implement FSM states IDLE, BIAS, MAC, DRAIN, EMIT, DONE with a single shared 8x8 multiplier.
REQ-019 IDLE: start=1 -> BIAS with neuron i=0; start in any other state SHALL be ignored.
REQ-020 BIAS (1 cycle): drive b_addr=i; -> MAC with j=0.
REQ-021 MAC (IN_SIZE cycles): drive in_addr=j, w_addr=i*IN_SIZE+j; at j=0 acc <= sign-extended b_data; at j>0 acc <= acc + in_data*w_data (product of j-1); after j=IN_SIZE-1 -> DRAIN.
REQ-022 DRAIN (1 cycle): acc <= acc + product of element IN_SIZE-1; -> EMIT.
REQ-023 EMIT (1 cycle): out_valid=1, out_idx=i, out_data=0 if acc<0, 127 if acc>127, else acc[7:0]; -> BIAS with i+1, or DONE if i=OUT_SIZE-1.
REQ-024 DONE (1 cycle): done=1; -> IDLE.
REQ-025 Accumulator SHALL be 24-bit signed; products 16-bit signed, sign-extended; no intermediate saturation or wrap for legal parameters.
REQ-026 Timing, start sampled at cycle 0: neuron n emitted at cycle (n+1)*(IN_SIZE+3); done at cycle OUT_SIZE*(IN_SIZE+3)+1; busy high cycles 1..OUT_SIZE*(IN_SIZE+3)+1.
REQ-027 out_idx/out_data SHALL hold last emitted values while out_valid=0.
REQ-028 Address outputs SHALL be 0 in IDLE and DONE.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle: no further out_valid, no done; abort in IDLE ignored; abort and start same cycle in IDLE -> abort wins (stay IDLE).
REQ-030 Neuron/element counters SHALL never exceed OUT_SIZE-1/IN_SIZE-1 (no wrap).

Reset
REQ-031 rst=1 SHALL at next edge force IDLE, clear acc/counters, and drive out_valid=0, done=0, busy=0, out_idx=0, out_data=0, all addresses=0; rst overrides start and abort.
REQ-032 rst mid-evaluation SHALL discard the evaluation; a start after rst deasserts SHALL run a full fresh evaluation.

Verification (IN_SIZE=4, OUT_SIZE=2, memories model 1-cycle latency)
REQ-033 rst held 3 cycles -> all outputs 0, busy=0; start during rst -> no activity.
REQ-034 inputs 1,2,3,4; row0 weights 1,1,1,1, bias0=5; row1 weights -1, bias1=0; start at cycle 0 -> out_valid at 7 (idx0, data 15), at 14 (idx1, data 0); done at 15; busy 1..15.
REQ-035 all inputs 127, weights 127, biases 127 -> out_data 127 both neurons (acc 64643 clamped).
REQ-036 inputs -128, weights -128, bias -128 -> acc 65408 -> 127; inputs -128, weights 127 -> 0.
REQ-037 start re-pulsed at cycle 5 -> ignored, timing identical to REQ-034; abort at cycle 5 -> busy=0 at cycle 6, no out_valid/done; new start then gives REQ-034 results.
REQ-038 rst at cycle 9 (after neuron 0 emitted) -> IDLE at cycle 10, no done; restart reproduces REQ-034 sequence.

Source files
------------

// File: rtl/nn_parameters.sv
// Shared network dimensions used as defaults by the layer blocks.
package nn_parameters;

  localparam int unsigned IN_SIZE_2  = 4;
  localparam int unsigned OUT_SIZE_2 = 2;

endpackage

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: one shared 8x8 multiplier walks each neuron's weight row,
// then emits the accumulator clamped to 0..127.
module dense_layer_seq #(
  parameter int unsigned IN_SIZE  = nn_parameters::IN_SIZE_2,
  parameter int unsigned OUT_SIZE = nn_parameters::OUT_SIZE_2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              abort,
  output logic [$clog2(IN_SIZE)-1:0]                        in_addr,
  input  logic signed [7:0]                                 in_data,
  output logic [$clog2(OUT_SIZE*IN_SIZE)-1:0]               w_addr,
  input  logic signed [7:0]                                 w_data,
  output logic [((OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1)-1:0] b_addr,
  input  logic signed [7:0]                                 b_data,
  output logic                                              out_valid,
  output logic [((OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1)-1:0] out_idx,
  output logic signed [7:0]                                 out_data,
  output logic                                              busy,
  output logic                                              done
);

  localparam int unsigned IW = $clog2(IN_SIZE);
  localparam int unsigned OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned WW = $clog2(OUT_SIZE * IN_SIZE);
  localparam int unsigned AW = 24;

  localparam logic [IW-1:0] JLAST = IW'(IN_SIZE - 1);
  localparam logic [OW-1:0] ILAST = OW'(OUT_SIZE - 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, EMIT, DONE} state_t;

  state_t               state, state_n;
  logic [OW-1:0]        i, i_n;
  logic [IW-1:0]        j, j_n;
  logic signed [AW-1:0] acc, acc_n, acc_sum;
  logic signed [15:0]   prod;

  logic [IW-1:0]        in_addr_n;
  logic [WW-1:0]        w_addr_n;
  logic [OW-1:0]        b_addr_n, out_idx_n;
  logic signed [7:0]    out_data_n;
  logic                 out_valid_n, busy_n, done_n;

  function automatic logic signed [7:0] clamp8(input logic signed [AW-1:0] a);
    if (a < 0)                  return 8'sd0;
    else if (a > AW'(sd127())) return 8'sd127;
    else                        return a[7:0];
  endfunction

  function automatic logic signed [AW-1:0] sd127();
    return AW'(127);
  endfunction

  // Memory data lags the address by one cycle, so this is always the previous element's product.
  assign prod    = 16'(in_data) * 16'(w_data);
  assign acc_sum = acc + AW'(prod);

  always_comb begin
    state_n     = state;
    i_n         = i;
    j_n         = j;
    acc_n       = acc;
    out_idx_n   = out_idx;
    out_data_n  = out_data;
    in_addr_n   = '0;
    w_addr_n    = '0;
    b_addr_n    = '0;
    out_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        j_n = '0;
        if (start && !abort) begin
          state_n = BIAS;
          i_n     = '0;
        end
      end
      BIAS: begin
        state_n = MAC;
        j_n     = '0;
      end
      MAC: begin
        acc_n = (j == '0) ? AW'(b_data) : acc_sum;
        if (j == JLAST) state_n = DRAIN;
        else            j_n     = j + 1'b1;
      end
      DRAIN: begin
        acc_n   = acc_sum;
        state_n = EMIT;
      end
      EMIT: begin
        if (i == ILAST) begin
          state_n = DONE;
        end else begin
          state_n = BIAS;
          i_n     = i + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort && state != IDLE) state_n = IDLE;

    // Outputs are registered, so decode them from the state being entered.
    busy_n      = (state_n != IDLE);
    out_valid_n = (state_n == EMIT);
    done_n      = (state_n == DONE);
    case (state_n)
      BIAS: b_addr_n = i_n;
      MAC: begin
        in_addr_n = j_n;
        w_addr_n  = WW'(32'(i_n) * IN_SIZE + 32'(j_n));
      end
      EMIT: begin
        out_idx_n  = i_n;
        out_data_n = clamp8(acc_n);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      j         <= j_n;
      acc       <= acc_n;
      in_addr   <= in_addr_n;
      w_addr    <= w_addr_n;
      b_addr    <= b_addr_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_data  <= out_data_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule
